// File: rtl/mcs4_addr_stack_if.sv
// Sequencer-to-address-unit bundle: resolved address op in, PC/stack status out.
interface mcs4_addr_stack_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              op_valid;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic              clr_err;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret_addr;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              end_of_page;
    logic              overflow;
    logic              underflow;

    modport master (
        output op_valid, op, target, clr_err,
        input  pc, ret_addr, level, full, empty, end_of_page, overflow, underflow
    );

    modport slave (
        input  op_valid, op, target, clr_err,
        output pc, ret_addr, level, full, empty, end_of_page, overflow, underflow
    );
endinterface

// File: rtl/mcs4_addr_stack.sv
// MCS-4 program counter with DEPTH-level return stack, page jumps and
// selectable circular-wrap or refuse-on-fault stack policy.
module mcs4_addr_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4,
    parameter bit STRICT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mcs4_addr_stack_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_JUMP  = 3'd2;
    localparam logic [2:0] OP_JPAGE = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [PTR_W-1:0]  wp_q;
    logic [PTR_W-1:0]  wp_inc;
    logic [PTR_W-1:0]  wp_dec;
    logic [LVL_W-1:0]  level_q;
    logic              ovf_q;
    logic              unf_q;
    logic              is_full;
    logic              is_empty;

    // Pointer wraps explicitly so non-power-of-two depths stay in range.
    always_comb begin
        pc_inc   = pc_q + 1'b1;
        wp_inc   = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
        wp_dec   = (wp_q == '0) ? PTR_LAST : wp_q - 1'b1;
        top      = stack_q[wp_dec];
        is_full  = (level_q == LVL_FULL);
        is_empty = (level_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            wp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            // Clear first; a fault set below in the same cycle overrides it.
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (bus.op_valid) begin
                case (bus.op)
                    OP_INC:   pc_q <= pc_inc;
                    OP_JUMP:  pc_q <= bus.target;
                    OP_JPAGE: pc_q <= {pc_inc[ADDR_W-1:8], bus.target[7:0]};
                    OP_CALL: begin
                        if (is_full) begin
                            ovf_q <= 1'b1;
                        end
                        if (!is_full || !STRICT) begin
                            stack_q[wp_q] <= pc_inc;
                            wp_q          <= wp_inc;
                            pc_q          <= bus.target;
                            if (!is_full) begin
                                level_q <= level_q + 1'b1;
                            end
                        end
                    end
                    OP_RET: begin
                        if (is_empty) begin
                            unf_q <= 1'b1;
                        end
                        if (!is_empty || !STRICT) begin
                            pc_q <= top;
                            wp_q <= wp_dec;
                            if (!is_empty) begin
                                level_q <= level_q - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.ret_addr    = is_empty ? '0 : top;
    assign bus.level       = level_q;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.end_of_page = (pc_q[7:0] == 8'hFF);
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
